// File: rtl/dot_frame_buffer.sv
// dot_frame_buffer
//   Double-buffered 8x8 frame store for the dot-matrix decoder. The CPU side
//   fills the back buffer one row at a time and then asks for a swap. The front
//   buffer, which drives q, changes only on a scan-frame boundary. This keeps
//   the display from ever showing a half-written image. An optional
//   auto-scroll rotates the displayed image one column every SCROLL_DIV frames.
//
// Ports
//   clk        in   1  system clock, rising edge
//   rst        in   1  synchronous active-high reset
//   we         in   1  row write strobe
//   addr       in   3  row index for the write
//   wdata      in   8  row pattern, bit c = column c lit
//   clr        in   1  clear the whole back buffer
//   swap       in   1  request commit of back -> front at next frame_tick
//   frame_tick in   1  one-cycle pulse at the start of each scan frame
//   scroll_en  in   1  enable auto-scroll of the front buffer
//   busy       out  1  swap pending (also the FSM state: 1 = PENDING)
//   q          out 64  front buffer, dot (r,c) = q[8*r+c]
//
// Swap handshake: a one-cycle swap pulse sampled while busy=0 is accepted,
// and busy rises after that edge. While busy=1, swap, we and clr are all
// ignored (nothing is queued). The first frame_tick sampled while busy=1
// commits the back buffer and drops busy. A tick in the same cycle as the
// accepting swap does not commit.
module dot_frame_buffer #(
  parameter int SCROLL_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [2:0]  addr,
  input  logic [7:0]  wdata,
  input  logic        clr,
  input  logic        swap,
  input  logic        frame_tick,
  input  logic        scroll_en,
  output logic        busy,
  output logic [63:0] q
);

  localparam int SW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [SW-1:0] SCNT_MAX = SW'(SCROLL_DIV - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t        state, state_next;
  logic [63:0]   back;
  logic [63:0]   front;
  logic [SW-1:0] scnt;
  logic          commit;
  logic [63:0]   front_rot;

  // Each row byte rotates left by one column. Column 7 wraps to column 0.
  always_comb begin
    front_rot = '0;
    for (int r = 0; r < 8; r++) begin
      front_rot[8*r +: 8] = {front[8*r +: 7], front[8*r + 7]};
    end
  end

  // Next-state logic. Commit is the PENDING -> IDLE transition.
  always_comb begin
    state_next = state;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (swap) state_next = PENDING;
      end
      PENDING: begin
        if (frame_tick) begin
          commit     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Back buffer. clr has priority over we. Both are ignored while a swap is
  // pending, so the image being committed cannot change under the commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      back <= '0;
    end else if (state == IDLE) begin
      if (clr) begin
        back <= '0;
      end else if (we) begin
        back[8*addr +: 8] <= wdata;
      end
    end
  end

  // Front buffer and scroll counter. A commit always beats a scroll step in
  // the same cycle, and it restarts the scroll period.
  always_ff @(posedge clk) begin
    if (rst) begin
      front <= '0;
      scnt  <= '0;
    end else if (commit) begin
      front <= back;
      scnt  <= '0;
    end else if (!scroll_en) begin
      scnt <= '0;
    end else if (frame_tick) begin
      if (scnt == SCNT_MAX) begin
        front <= front_rot;
        scnt  <= '0;
      end else begin
        scnt <= scnt + 1'b1;
      end
    end
  end

  assign busy = (state == PENDING);
  assign q    = front;

endmodule

// File: tb/tb_dot_frame_buffer.sv
// tb_dot_frame_buffer
//   Self-checking bench for dot_frame_buffer with SCROLL_DIV = 4. Expected
//   front-buffer images are pushed to exp_q when stimulus is driven and popped
//   when the DUT output is sampled (1 time unit after the active edge).
module tb_dot_frame_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [2:0]  addr;
  logic [7:0]  wdata;
  logic        clr;
  logic        swap;
  logic        frame_tick;
  logic        scroll_en;
  logic        busy;
  logic [63:0] q;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] e;

  dot_frame_buffer #(.SCROLL_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .clr        (clr),
    .swap       (swap),
    .frame_tick (frame_tick),
    .scroll_en  (scroll_en),
    .busy       (busy),
    .q          (q)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic drv_write(input logic [2:0] a, input logic [7:0] d);
    we = 1'b1; addr = a; wdata = d;
    cyc();
    we = 1'b0;
  endtask

  task automatic drv_clr();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
  endtask

  task automatic drv_clr_we(input logic [2:0] a, input logic [7:0] d);
    clr = 1'b1; we = 1'b1; addr = a; wdata = d;
    cyc();
    clr = 1'b0; we = 1'b0;
  endtask

  task automatic drv_swap();
    swap = 1'b1;
    cyc();
    swap = 1'b0;
  endtask

  task automatic drv_tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
  endtask

  task automatic drv_swap_tick();
    swap = 1'b1; frame_tick = 1'b1;
    cyc();
    swap = 1'b0; frame_tick = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drv_reset();
    exp_q.push_back(64'h0);
    e = exp_q.pop_front(); checks++;
    if (q !== e) begin errors++; $display("FAIL reset_q q=%h exp=%h", q, e); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy busy=%b exp=0", busy); end
  endtask

  task automatic test_swap_commit();
    for (int i = 0; i < 8; i++) drv_write(3'(i), 8'(1 << i));
    exp_q.push_back(64'h0);
    drv_swap();
    e = exp_q.pop_front(); checks++;
    if (q !== e) begin errors++; $display("FAIL commit_pre_q q=%h exp=%h", q, e); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL commit_busy_set busy=%b exp=1", busy); end
    cyc();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL commit_busy_hold busy=%b exp=1", busy); end
    exp_q.push_back(64'h8040201008040201);
    drv_tick();
    e = exp_q.pop_front(); checks++;
    if (q !== e) begin errors++; $display("FAIL commit_q q=%h exp=%h", q, e); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL commit_busy_clr busy=%b exp=0", busy); end
  endtask

  task automatic test_swap_tick_same();
    drv_write(3'd0, 8'h55);
    exp_q.push_back(64'h8040201008040201);
    drv_swap_tick();
    e = exp_q.pop_front(); checks++;
    if (q !== e) begin errors++; $display("FAIL same_cycle_q q=%h exp=%h", q, e); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL same_cycle_busy busy=%b exp=1", busy); end
    exp_q.push_back(64'h8040201008040255);
    drv_tick();
    e = exp_q.pop_front(); checks++;
    if (q !== e) begin errors++; $display("FAIL same_cycle_commit q=%h exp=%h", q, e); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL same_cycle_busy_clr busy=%b exp=0", busy); end
  endtask

  task automatic test_busy_ignore();
    drv_clr();
    drv_write(3'd2, 8'h3C);
    drv_swap();
    drv_write(3'd3, 8'hFF);
    drv_clr();
    drv_clr_we(3'd4, 8'h99);
    exp_q.push_back(64'h0000_0000_003C_0000);
    drv_tick();
    e = exp_q.pop_front(); checks++;
    if (q !== e) begin errors++; $display("FAIL busy_ignore_q q=%h exp=%h", q, e); end
    // clr and we together while idle: clr wins, back becomes 0
    drv_clr_we(3'd5, 8'h77);
    drv_swap();
    exp_q.push_back(64'h0);
    drv_tick();
    e = exp_q.pop_front(); checks++;
    if (q !== e) begin errors++; $display("FAIL clr_wins_q q=%h exp=%h", q, e); end
  endtask

  task automatic test_scroll();
    drv_clr();
    drv_write(3'd0, 8'h81);
    drv_swap();
    exp_q.push_back(64'h81);
    drv_tick();
    e = exp_q.pop_front(); checks++;
    if (q !== e) begin errors++; $display("FAIL scroll_load q=%h exp=%h", q, e); end
    scroll_en = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      if (t < 4) exp_q.push_back(64'h81);
      else if (t < 8) exp_q.push_back(64'h03);
      else exp_q.push_back(64'h06);
      drv_tick();
      e = exp_q.pop_front(); checks++;
      if (q !== e) begin errors++; $display("FAIL scroll_tick%0d q=%h exp=%h", t, q, e); end
    end
    scroll_en = 1'b0;
    drv_clr();
    drv_write(3'd0, 8'h80);
    drv_swap();
    drv_tick();
    scroll_en = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      exp_q.push_back((t < 4) ? 64'h80 : 64'h01);
      drv_tick();
      e = exp_q.pop_front(); checks++;
      if (q !== e) begin errors++; $display("FAIL scroll_wrap%0d q=%h exp=%h", t, q, e); end
    end
    scroll_en = 1'b0;
    cyc();
  endtask

  task automatic test_commit_vs_scroll();
    drv_clr();
    drv_write(3'd1, 8'h11);
    scroll_en = 1'b1;
    for (int t = 1; t <= 3; t++) drv_tick();
    exp_q.push_back(64'h01);
    e = exp_q.pop_front(); checks++;
    if (q !== e) begin errors++; $display("FAIL cvs_pre q=%h exp=%h", q, e); end
    drv_swap();
    exp_q.push_back(64'h1100);
    drv_tick();
    e = exp_q.pop_front(); checks++;
    if (q !== e) begin errors++; $display("FAIL cvs_commit q=%h exp=%h", q, e); end
    for (int t = 1; t <= 4; t++) begin
      exp_q.push_back((t < 4) ? 64'h1100 : 64'h2200);
      drv_tick();
      e = exp_q.pop_front(); checks++;
      if (q !== e) begin errors++; $display("FAIL cvs_after%0d q=%h exp=%h", t, q, e); end
    end
    scroll_en = 1'b0;
    cyc();
  endtask

  task automatic test_reset_pending();
    drv_write(3'd7, 8'hAA);
    drv_swap();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rstp_busy_pre busy=%b exp=1", busy); end
    exp_q.push_back(64'h0);
    drv_reset();
    e = exp_q.pop_front(); checks++;
    if (q !== e) begin errors++; $display("FAIL rstp_q q=%h exp=%h", q, e); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rstp_busy busy=%b exp=0", busy); end
    exp_q.push_back(64'h0);
    drv_tick();
    e = exp_q.pop_front(); checks++;
    if (q !== e) begin errors++; $display("FAIL rstp_tick_q q=%h exp=%h", q, e); end
    // back buffer was cleared by reset too
    drv_swap();
    exp_q.push_back(64'h0);
    drv_tick();
    e = exp_q.pop_front(); checks++;
    if (q !== e) begin errors++; $display("FAIL rstp_back_q q=%h exp=%h", q, e); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b0; we = 1'b0; addr = 3'd0; wdata = 8'h00; clr = 1'b0;
    swap = 1'b0; frame_tick = 1'b0; scroll_en = 1'b0;
    test_reset();
    test_swap_commit();
    test_swap_tick_same();
    test_busy_ignore();
    test_scroll();
    test_commit_vs_scroll();
    test_reset_pending();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dot_frame_buffer.md
# dot_frame_buffer

Double-buffered 8x8 frame store feeding the dot-matrix decoder's 64-bit `d` input. The CPU side writes the back buffer one row at a time and requests a swap; the front buffer, which drives `q`, updates only on a scan-frame boundary (`frame_tick`), so the display never shows a half-written image. An optional auto-scroll rotates the displayed image one column every `SCROLL_DIV` frames.

## Interface
- `SCROLL_DIV`, 4: frame ticks per one-column scroll step (>=1).
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `we`  in  1  row write strobe (one cycle per row).
- `addr`  in  3  row index r for the write.
- `wdata`  in  8  row pattern; bit c = column c lit.
- `clr`  in  1  clear the whole back buffer to 0.
- `swap`  in  1  request to commit the back buffer to the front at the next frame boundary.
- `frame_tick`  in  1  one-cycle pulse at the start of each scan frame.
- `scroll_en`  in  1  enable auto-scroll of the front buffer.
- `busy`  out  1  swap pending; back-buffer writes and clears are ignored.
- `q`  out  64  front buffer; dot (row r, column c) = `q[8*r+c]`, to decoder `d`.

## Operation
- Storage: `back[63:0]` and `front[63:0]` registers; `q` = `front` directly (no combinational path from inputs).
- Write: if `we` && !`busy` && !`clr`: `back[8*addr +: 8]` <= `wdata`; other rows unchanged.
- Clear: if `clr` && !`busy`: `back` <= 0. When `clr` and `we` occur in the same cycle, `clr` wins.
- FSM, 2 states:
  - IDLE (`busy`=0): `swap`=1 -> PENDING. `frame_tick` in the same cycle as `swap` does not commit; the commit waits for the next tick.
  - PENDING (`busy`=1): `swap` is ignored (no queuing). On `frame_tick`: `front` <= `back`, scroll counter <= 0, -> IDLE.
- Scroll counter `scnt`, width clog2(SCROLL_DIV), minimum 1 bit:
  - `scroll_en`=0: `scnt` <= 0 and no rotation.
  - `scroll_en`=1 and `frame_tick` with no commit this cycle:
    - If `scnt` == SCROLL_DIV-1: each row byte of `front` rotates left by 1 (new column c = old column (c-1) mod 8; column 7 wraps to column 0), and `scnt` <= 0.
    - Otherwise `scnt` <= `scnt`+1.
  - Commit and scroll step in the same cycle: commit wins, no rotation, `scnt` <= 0.
- Scrolling changes only `front`; `back` is never rotated.
- Reset: `back`=0, `front`=0 (`q`=0), state IDLE (`busy`=0), `scnt`=0. Reset overrides every other input in that cycle, and an in-progress PENDING swap is discarded.

## Timing
- Write and clear latency: `back` is updated at the edge that samples the strobe. A write is visible in `q` only after a commit.
- `swap` sampled at edge N sets `busy`=1 after edge N.
- Commit: `frame_tick` sampled at edge M while PENDING gives `q` = `back` and `busy`=0 after edge M.
- A write in the same cycle as the committing tick is ignored because `busy`=1.
- Scroll: `q` changes only after an edge that samples `frame_tick`. With `scroll_en` held, one rotation occurs every SCROLL_DIV ticks.
- No input requires more than one cycle of assertion. Multi-cycle `frame_tick` counts as one tick per cycle.

## Test plan
- Reset, then write rows 0..7 with 0x01,0x02,..,0x80, then `swap`, then `frame_tick` -> `busy` is 1 until the tick; `q` = 0x8040201008040201 after the tick edge, and `q` = 0 before it.
- `swap` and `frame_tick` in the same cycle from IDLE -> `busy`=1 and `q` unchanged; the next `frame_tick` commits the buffer.
- While `busy`=1, `we` addr=3 wdata=0xFF and `clr` -> both ignored; after the commit `q` equals the pre-swap `back`. A subsequent `clr` and `we` in the same cycle leave `back`=0.
- SCROLL_DIV=4, `front` row 0 = 0x81, `scroll_en`=1, 8 ticks -> row 0 becomes 0x03 after tick 4 and 0x06 after tick 8. Row 0 = 0x80 wraps to 0x01.
- `scnt` at 3 with a pending swap, then `frame_tick` -> the commit occurs with no rotation; the next rotation comes 4 ticks later.
- `rst` asserted while PENDING with `front` nonzero -> next cycle `q`=0 and `busy`=0; `frame_tick` afterwards leaves `q`=0.
